// File: rtl/slipstream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : slipstream_pkg
// Purpose : Shared types and constants for the Slipstream counter chains.
// Rev     : 1.0  initial counter readback additions
// ============================================================================
package slipstream_pkg;

  typedef enum logic [0:0] {
    CT_RL_IDLE = 1'b0,
    CT_RL_HELD = 1'b1
  } ct_rl_state_t;

  localparam logic [7:0] CT_RL_ELAPSED_MAX = 8'hFF;

  // Byte-select width; a single-byte counter still carries a 1-bit select.
  function automatic int ct_rl_aw(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_rl_satcnt.sv
`default_nettype none
// ============================================================================
// Module  : ct_rl_satcnt
// Purpose : 8-bit saturating counter with synchronous clear and enable.
// Rev     : 1.0  initial
// ============================================================================
module ct_rl_satcnt
  import slipstream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  // Clear has priority over enable so a capture on a tick edge starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'h00;
    end else if (i_clr) begin
      r_cnt <= 8'h00;
    end else if (i_en && (r_cnt != CT_RL_ELAPSED_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ct_read_latch.sv
`default_nettype none
// ============================================================================
// Module  : ct_read_latch
// Purpose : Byte-serial CPU readback of a running counter with a coherent
//           snapshot taken on the low-byte read and a staleness count.
// Rev     : 1.0  initial
// ============================================================================
module ct_read_latch
  import slipstream_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NB    = WIDTH / 8,
  localparam int AW    = ct_rl_aw(WIDTH / 8)
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic [WIDTH-1:0] CT_VAL,
  input  logic             CT_TICK,
  input  logic             RD,
  input  logic [AW-1:0]    RA,
  output logic [7:0]       DOUT,
  output logic             HELD,
  output logic [7:0]       ELAPSED
);

  ct_rl_state_t     r_state;
  logic [WIDTH-1:0] r_snap;
  logic [7:0]       r_dout;

  logic [7:0]       w_live_byte;
  logic [7:0]       w_snap_byte;
  logic             w_ra_valid;
  logic             w_ra_zero;
  logic             w_ra_top;
  logic             w_capture;
  logic             w_tick_held;

  // Out-of-range selects (non-power-of-two byte counts) match no byte.
  always_comb begin
    w_live_byte = 8'h00;
    w_snap_byte = 8'h00;
    w_ra_valid  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (RA == AW'(i)) begin
        w_live_byte = CT_VAL[i*8 +: 8];
        w_snap_byte = r_snap[i*8 +: 8];
        w_ra_valid  = 1'b1;
      end
    end
  end

  assign w_ra_zero   = (RA == '0);
  assign w_ra_top    = (RA == AW'(NB - 1));
  assign w_capture   = RD && w_ra_zero;
  assign w_tick_held = CT_TICK && (r_state == CT_RL_HELD);

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_state <= CT_RL_IDLE;
      r_dout  <= 8'h00;
      r_snap  <= '0;
    end else if (RD) begin
      if (!w_ra_valid) begin
        r_dout <= 8'h00;
      end else if (w_ra_zero) begin
        // Snapshot and low byte come from the same edge, so later bytes match.
        r_snap  <= CT_VAL;
        r_dout  <= CT_VAL[7:0];
        r_state <= (NB > 1) ? CT_RL_HELD : CT_RL_IDLE;
      end else if (r_state == CT_RL_IDLE) begin
        r_dout <= w_live_byte;
      end else begin
        r_dout <= w_snap_byte;
        if (w_ra_top) begin
          r_state <= CT_RL_IDLE;
        end
      end
    end
  end

  ct_rl_satcnt u_elapsed (
    .clk   (MasterClock),
    .rst   (RESET),
    .i_clr (w_capture),
    .i_en  (w_tick_held),
    .o_cnt (ELAPSED)
  );

  assign DOUT = r_dout;
  assign HELD = (r_state == CT_RL_HELD);

endmodule
`default_nettype wire

// File: tb/tb_ct_read_latch.sv
`default_nettype none
// Bench for ct_read_latch: three widths (16, 24, 8) driven together, a queued
// scoreboard fed from a behavioural model, plus headline directed checks.
module tb_ct_read_latch;

  logic        clk = 1'b0;
  logic        rst, tick;
  logic        rd16, rd24, rd8;
  logic [0:0]  ra16, ra8;
  logic [1:0]  ra24;
  logic [15:0] val16;
  logic [23:0] val24;
  logic [7:0]  val8;
  logic [7:0]  dout16, dout24, dout8, el16, el24, el8;
  logic        held16, held24, held8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ct_read_latch #(.WIDTH(16)) u16 (
    .MasterClock(clk), .RESET(rst), .CT_VAL(val16), .CT_TICK(tick), .RD(rd16),
    .RA(ra16), .DOUT(dout16), .HELD(held16), .ELAPSED(el16));
  ct_read_latch #(.WIDTH(24)) u24 (
    .MasterClock(clk), .RESET(rst), .CT_VAL(val24), .CT_TICK(tick), .RD(rd24),
    .RA(ra24), .DOUT(dout24), .HELD(held24), .ELAPSED(el24));
  ct_read_latch #(.WIDTH(8)) u8 (
    .MasterClock(clk), .RESET(rst), .CT_VAL(val8), .CT_TICK(tick), .RD(rd8),
    .RA(ra8), .DOUT(dout8), .HELD(held8), .ELAPSED(el8));

  // Reference model: reader state as plain integers.
  typedef struct {
    int    nb;
    bit    held;
    longint snap;
    int    dout;
    int    el;
  } mdl_t;

  typedef struct {
    int inst;
    int dout;
    bit held;
    int el;
  } exp_t;

  mdl_t m16, m24, m8;
  exp_t sb[$];

  function automatic mdl_t mstep(mdl_t m, bit r, bit rd, int ra, longint val, bit tk);
    mdl_t n = m;
    if (r) begin
      n.held = 0; n.snap = 0; n.dout = 0; n.el = 0;
      return n;
    end
    if (m.held && tk && n.el < 255) n.el = n.el + 1;
    if (rd) begin
      if (ra >= m.nb) n.dout = 0;
      else if (ra == 0) begin
        n.snap = val;
        n.dout = int'(val % 256);
        n.el   = 0;
        n.held = (m.nb > 1);
      end else if (!m.held) n.dout = int'((val >> (8 * ra)) % 256);
      else begin
        n.dout = int'((m.snap >> (8 * ra)) % 256);
        if (ra == m.nb - 1) n.held = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: model advances on the same edge as the DUTs, expectations queued.
  task automatic clock_step();
    @(posedge clk);
    m16 = mstep(m16, rst, rd16, int'(ra16), longint'(val16), tick);
    m24 = mstep(m24, rst, rd24, int'(ra24), longint'(val24), tick);
    m8  = mstep(m8,  rst, rd8,  int'(ra8),  longint'(val8),  tick);
    sb.push_back('{16, m16.dout, m16.held, m16.el});
    sb.push_back('{24, m24.dout, m24.held, m24.el});
    sb.push_back('{8,  m8.dout,  m8.held,  m8.el});
    @(negedge clk);
    #1;
    rst = 0; tick = 0; rd16 = 0; rd24 = 0; rd8 = 0;
  endtask

  // Monitor: every cycle all three readers present outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.inst)
        16: begin
          chk("w16_dout", int'(dout16), e.dout);
          chk("w16_held", int'(held16), int'(e.held));
          chk("w16_elapsed", int'(el16), e.el);
        end
        24: begin
          chk("w24_dout", int'(dout24), e.dout);
          chk("w24_held", int'(held24), int'(e.held));
          chk("w24_elapsed", int'(el24), e.el);
        end
        default: begin
          chk("w8_dout", int'(dout8), e.dout);
          chk("w8_held", int'(held8), int'(e.held));
          chk("w8_elapsed", int'(el8), e.el);
        end
      endcase
    end
  end

  initial begin
    m16 = '{2, 0, 0, 0, 0};
    m24 = '{3, 0, 0, 0, 0};
    m8  = '{1, 0, 0, 0, 0};
    rst = 1; tick = 0; rd16 = 0; rd24 = 0; rd8 = 0;
    ra16 = 0; ra24 = 0; ra8 = 0; val16 = 0; val24 = 0; val8 = 0;
    clock_step();
    rst = 1;
    clock_step();
    chk("reset_dout", int'(dout16), 0);
    chk("reset_held", int'(held16), 0);

    // Live reads in IDLE on the 24-bit reader.
    val24 = 24'hA1B2C3; rd24 = 1; ra24 = 2; clock_step();
    chk("live_ra2", int'(dout24), 8'hA1);
    rd24 = 1; ra24 = 1; clock_step();
    chk("live_ra1", int'(dout24), 8'hB2);
    chk("live_held", int'(held24), 0);
    rd24 = 1; ra24 = 3; clock_step();
    chk("live_ra3", int'(dout24), 8'h00);

    // Single-byte reader never holds.
    val8 = 8'h7E; rd8 = 1; ra8 = 0; clock_step();
    chk("w8_cap", int'(dout8), 8'h7E);
    chk("w8_noheld", int'(held8), 0);

    // Coherent read across a carry.
    val16 = 16'h12FF; rd16 = 1; ra16 = 0; clock_step();
    chk("coh_lo", int'(dout16), 8'hFF);
    chk("coh_held", int'(held16), 1);
    val16 = 16'h1300; tick = 1; clock_step();
    rd16 = 1; ra16 = 1; clock_step();
    chk("coh_hi", int'(dout16), 8'h12);
    chk("coh_release", int'(held16), 0);

    // Staleness saturation, hold after release, clear on next capture.
    rd16 = 1; ra16 = 0; clock_step();
    for (int i = 0; i < 300; i++) begin
      tick = 1; val16 = val16 + 16'd1; clock_step();
    end
    chk("stale_sat", int'(el16), 255);
    rd16 = 1; ra16 = 1; clock_step();
    tick = 1; clock_step();
    chk("stale_hold_idle", int'(el16), 255);
    rd16 = 1; ra16 = 0; clock_step();
    chk("stale_clear", int'(el16), 0);

    // Capture on a tick edge: capture wins.
    val16 = 16'h00AB; rd16 = 1; ra16 = 0; tick = 1; clock_step();
    chk("simul_lo", int'(dout16), 8'hAB);
    chk("simul_el", int'(el16), 0);
    chk("simul_held", int'(held16), 1);

    // Reset mid-sequence abandons the snapshot.
    val16 = 16'h5566; rd16 = 1; ra16 = 0; clock_step();
    val16 = 16'h7788; rst = 1; clock_step();
    chk("rst_mid_dout", int'(dout16), 0);
    chk("rst_mid_held", int'(held16), 0);
    rd16 = 1; ra16 = 1; clock_step();
    chk("rst_mid_live", int'(dout16), 8'h77);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      tick  = 1'($urandom_range(0, 1));
      rd16  = 1'($urandom_range(0, 1));
      rd24  = 1'($urandom_range(0, 1));
      rd8   = 1'($urandom_range(0, 3) == 0);
      ra16  = 1'($urandom_range(0, 1));
      ra24  = 2'($urandom_range(0, 3));
      ra8   = 1'($urandom_range(0, 1));
      val16 = 16'($urandom);
      val24 = 24'($urandom);
      val8  = 8'($urandom);
      clock_step();
    end

    clock_step();
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
